// File: rtl/pwm_demodulator.sv
// Recovers duty samples from a PWM line, flags period errors and stuck lines; sample_valid 3 clk after pwm rise.
// Strobe-only output with no backpressure; en=0 or rst discards any partial period.
module pwm_demodulator #(
  parameter int PWM_STEPS = 256,
  parameter int TOL       = 2,
  parameter int SW        = $clog2(PWM_STEPS + 1),
  parameter int CW        = $clog2(2 * PWM_STEPS + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_pwm,
  output logic [SW-1:0] o_sample,
  output logic          o_sample_valid,
  output logic          o_period_err,
  output logic          o_stuck,
  output logic          o_locked
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEASURE,
    S_STUCK
  } state_t;

  localparam logic [CW-1:0] L_MAX   = CW'(2 * PWM_STEPS);
  localparam logic [CW-1:0] L_STEPS = CW'(PWM_STEPS);
  localparam logic [CW-1:0] L_ONE   = CW'(1);
  localparam logic [CW:0]   L_HI    = (CW + 1)'(PWM_STEPS + TOL);
  localparam logic [CW:0]   L_LO    = (CW + 1)'(PWM_STEPS - TOL);
  localparam logic [SW-1:0] L_FULL  = SW'(PWM_STEPS);

  state_t        r_state;
  logic          r_sync1;
  logic          r_pwm_s;
  logic          r_pwm_d;
  logic [CW-1:0] r_per_cnt;
  logic [CW-1:0] r_hi_cnt;
  logic [SW-1:0] r_sample;
  logic          r_valid;
  logic          r_perr;
  logic          r_stuck;
  logic          r_locked;

  state_t        w_state_nx;
  logic [CW-1:0] w_per_nx;
  logic [CW-1:0] w_hi_nx;
  logic [SW-1:0] w_sample_nx;
  logic          w_valid_nx;
  logic          w_perr_nx;
  logic          w_stuck_nx;
  logic          w_locked_nx;
  logic          w_rise;
  logic [CW-1:0] w_per_inc;
  logic [CW-1:0] w_hi_inc;
  logic          w_per_bad;
  logic [SW-1:0] w_duty;

  assign w_rise    = r_pwm_s & ~r_pwm_d;
  assign w_per_inc = (r_per_cnt == L_MAX) ? L_MAX : r_per_cnt + 1'b1;
  assign w_hi_inc  = ((r_hi_cnt == L_MAX) || !r_pwm_s) ? r_hi_cnt : r_hi_cnt + 1'b1;
  assign w_per_bad = ({1'b0, r_per_cnt} > L_HI) || ({1'b0, r_per_cnt} < L_LO);
  // A glitchy long period can count more high cycles than a full period holds.
  assign w_duty    = (r_hi_cnt > L_STEPS) ? L_FULL : r_hi_cnt[SW-1:0];

  always_comb begin
    w_state_nx  = r_state;
    w_per_nx    = w_per_inc;
    w_hi_nx     = w_hi_inc;
    w_sample_nx = r_sample;
    w_valid_nx  = 1'b0;
    w_perr_nx   = r_perr;
    w_stuck_nx  = r_stuck;
    w_locked_nx = r_locked;
    case (r_state)
      S_IDLE: begin
        w_hi_nx = '0;
        if (w_rise) begin
          w_state_nx = S_MEASURE;
          w_per_nx   = L_ONE;
          w_hi_nx    = L_ONE;
        end else if (r_per_cnt == L_MAX) begin
          w_state_nx  = S_STUCK;
          w_per_nx    = L_ONE;
          w_stuck_nx  = 1'b1;
          w_locked_nx = 1'b0;
        end
      end
      S_MEASURE: begin
        if (w_rise) begin
          w_sample_nx = w_duty;
          w_valid_nx  = 1'b1;
          w_perr_nx   = w_per_bad;
          w_locked_nx = ~w_per_bad;
          w_per_nx    = L_ONE;
          w_hi_nx     = L_ONE;
        end else if (r_per_cnt == L_MAX) begin
          w_state_nx  = S_STUCK;
          w_per_nx    = L_ONE;
          w_stuck_nx  = 1'b1;
          w_locked_nx = 1'b0;
        end
      end
      S_STUCK: begin
        w_hi_nx = r_hi_cnt;
        // A rise on the wrap cycle takes priority; that partial period is dropped.
        if (w_rise) begin
          w_state_nx = S_MEASURE;
          w_per_nx   = L_ONE;
          w_hi_nx    = L_ONE;
          w_stuck_nx = 1'b0;
        end else if (r_per_cnt == L_STEPS) begin
          w_per_nx    = L_ONE;
          w_valid_nx  = 1'b1;
          w_sample_nx = r_pwm_s ? L_FULL : '0;
          w_perr_nx   = 1'b1;
        end
      end
      default: begin
        w_state_nx = S_IDLE;
        w_per_nx   = '0;
        w_hi_nx    = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || !i_en) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b0;
      r_pwm_s   <= 1'b0;
      r_pwm_d   <= 1'b0;
      r_per_cnt <= '0;
      r_hi_cnt  <= '0;
      r_sample  <= '0;
      r_valid   <= 1'b0;
      r_perr    <= 1'b0;
      r_stuck   <= 1'b0;
      r_locked  <= 1'b0;
    end else begin
      r_state   <= w_state_nx;
      r_sync1   <= i_pwm;
      r_pwm_s   <= r_sync1;
      r_pwm_d   <= r_pwm_s;
      r_per_cnt <= w_per_nx;
      r_hi_cnt  <= w_hi_nx;
      r_sample  <= w_sample_nx;
      r_valid   <= w_valid_nx;
      r_perr    <= w_perr_nx;
      r_stuck   <= w_stuck_nx;
      r_locked  <= w_locked_nx;
    end
  end

  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_period_err   = r_perr;
  assign o_stuck        = r_stuck;
  assign o_locked       = r_locked;

endmodule
